// File: rtl/line_buffer_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_regfile_pkg
// Desc     : Shared constants and types for the line-buffer APB register file
// Revision : 1.0 - initial release
// ============================================================================
package line_buffer_regfile_pkg;

  // Byte offsets of the register map
  localparam int unsigned CFG_BASE    = 'h000;
  localparam int unsigned COMMIT_OFS  = 'h100;
  localparam int unsigned IRQ_STS_OFS = 'h104;
  localparam int unsigned IRQ_EN_OFS  = 'h108;
  localparam int unsigned VERSION_OFS = 'h10C;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

  // APB slave transfer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACC = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_RD_ACC = 2'd3
  } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_irq_sts.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_irq_sts
// Desc     : Sticky W1C interrupt-status bank with enable mask and
//            registered level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_irq_sts #(
  parameter int NUM_STS = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_STS-1:0] i_sts_event,
  input  logic               i_clr_we,
  input  logic               i_en_we,
  input  logic [NUM_STS-1:0] i_wdata,
  output logic [NUM_STS-1:0] o_irq_sts,
  output logic [NUM_STS-1:0] o_irq_en,
  output logic               o_irq
);

  logic [NUM_STS-1:0] r_sts;
  logic [NUM_STS-1:0] r_en;
  logic               r_irq;
  logic [NUM_STS-1:0] w_clr;

  assign w_clr = i_clr_we ? i_wdata : '0;

  // Sticky status: an event in the same cycle as a clear keeps the bit set
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_sts <= '0;
    else          r_sts <= (r_sts & ~w_clr) | i_sts_event;
  end

  // Interrupt enable mask
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)     r_en <= '0;
    else if (i_en_we) r_en <= i_wdata;
  end

  // Level interrupt, one cycle behind the status/enable registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_irq <= 1'b0;
    else          r_irq <= |(r_sts & r_en);
  end

  assign o_irq_sts = r_sts;
  assign o_irq_en  = r_en;
  assign o_irq     = r_irq;

endmodule
`default_nettype wire

// File: rtl/line_buffer_regfile.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_regfile
// Desc     : APB register file with shadow/active configuration words
//            committed on frame_sync and a sticky interrupt-status bank
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_regfile
  import line_buffer_regfile_pkg::*;
#(
  parameter int          NUM_CFG = 8,
  parameter int          NUM_STS = 16,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic                  frame_sync,
  input  logic [NUM_STS-1:0]    sts_event,
  output logic [NUM_CFG*32-1:0] cfg_active,
  output logic                  commit_done,
  output logic                  irq
);

  localparam int WIDX_W = ADDR_W - 2;

  localparam logic [WIDX_W-1:0] C_CFG_IDX     = WIDX_W'(CFG_BASE >> 2);
  localparam logic [WIDX_W-1:0] C_CFG_WORDS   = WIDX_W'(NUM_CFG);
  localparam logic [WIDX_W-1:0] C_COMMIT_IDX  = WIDX_W'(COMMIT_OFS >> 2);
  localparam logic [WIDX_W-1:0] C_IRQ_STS_IDX = WIDX_W'(IRQ_STS_OFS >> 2);
  localparam logic [WIDX_W-1:0] C_IRQ_EN_IDX  = WIDX_W'(IRQ_EN_OFS >> 2);
  localparam logic [WIDX_W-1:0] C_VERSION_IDX = WIDX_W'(VERSION_OFS >> 2);

  apb_state_t         r_state;
  logic [31:0]        r_shadow [NUM_CFG];
  logic [31:0]        r_active [NUM_CFG];
  logic               r_pending;

  logic [WIDX_W-1:0]  w_idx;
  logic [WIDX_W-1:0]  w_cfg_off;
  logic               w_hit_cfg, w_hit_commit, w_hit_sts, w_hit_en, w_hit_ver;
  logic               w_err;
  logic               w_wr;
  logic               w_commit_wr;
  logic               w_apply;
  logic [31:0]        w_rdata;
  logic [NUM_STS-1:0] w_irq_sts;
  logic [NUM_STS-1:0] w_irq_en;
  logic               w_unused_addr_lsb;

  // Word-granular decode; the byte lane bits carry no meaning
  assign w_idx             = paddr[ADDR_W-1:2];
  assign w_unused_addr_lsb = ^paddr[1:0];
  assign w_cfg_off         = w_idx - C_CFG_IDX;
  assign w_hit_cfg         = (w_cfg_off < C_CFG_WORDS);
  assign w_hit_commit      = (w_idx == C_COMMIT_IDX);
  assign w_hit_sts         = (w_idx == C_IRQ_STS_IDX);
  assign w_hit_en          = (w_idx == C_IRQ_EN_IDX);
  assign w_hit_ver         = (w_idx == C_VERSION_IDX);
  assign w_err = !(w_hit_cfg | w_hit_commit | w_hit_sts | w_hit_en | w_hit_ver)
               | (pwrite & w_hit_ver);

  // The write lands at the edge closing the single ACCESS cycle
  assign w_wr        = (r_state == ST_WR_ACC) && psel && penable && !w_err;
  assign w_commit_wr = w_wr && w_hit_commit && pwdata[0];
  assign w_apply     = frame_sync && r_pending;

  // Read-back mux; unmapped offsets return zero
  always_comb begin
    w_rdata = '0;
    if (w_hit_cfg) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (w_cfg_off == WIDX_W'(i)) w_rdata = r_shadow[i];
      end
    end
    else if (w_hit_commit) w_rdata = {31'd0, r_pending};
    else if (w_hit_sts)    w_rdata = 32'(w_irq_sts);
    else if (w_hit_en)     w_rdata = 32'(w_irq_en);
    else if (w_hit_ver)    w_rdata = VERSION;
  end

  // APB slave FSM with registered pready/pslverr/prdata
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end
    else begin
      case (r_state)
        ST_IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          if (psel && !penable) begin
            if (pwrite) begin
              r_state <= ST_WR_ACC;
              pready  <= 1'b1;
              pslverr <= w_err;
            end
            else begin
              r_state <= ST_RD_CAP;
            end
          end
        end
        ST_RD_CAP: begin
          if (psel) begin
            r_state <= ST_RD_ACC;
            pready  <= 1'b1;
            pslverr <= w_err;
            prdata  <= w_err ? '0 : w_rdata;
          end
          else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end

  // Shadow writes, commit request and frame-synchronous shadow->active copy
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_pending   <= 1'b0;
      commit_done <= 1'b0;
    end
    else begin
      commit_done <= w_apply;
      // A request arriving with this frame_sync stays pending for the next one
      r_pending   <= (r_pending && !frame_sync) || w_commit_wr;
      for (int i = 0; i < NUM_CFG; i++) begin
        if (w_apply) r_active[i] <= r_shadow[i];
        if (w_wr && w_hit_cfg && (w_cfg_off == WIDX_W'(i))) r_shadow[i] <= pwdata;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_word
      assign cfg_active[32*g +: 32] = r_active[g];
    end
  endgenerate

  line_buffer_irq_sts #(
    .NUM_STS (NUM_STS)
  ) u_irq_sts (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_sts_event (sts_event),
    .i_clr_we    (w_wr && w_hit_sts),
    .i_en_we     (w_wr && w_hit_en),
    .i_wdata     (pwdata[NUM_STS-1:0]),
    .o_irq_sts   (w_irq_sts),
    .o_irq_en    (w_irq_en),
    .o_irq       (irq)
  );

endmodule
`default_nettype wire
